descf_arbiter: RTL and testbench
================================

// Module: descf_arbiter
// PURPOSE
//  Two-requester arbiter for the 256x32 single-port descriptor RAM (descf).
//  Port A is the CPU Avalon slave path; port B is the DMA descriptor fetcher.
//  Grants one access per clk, round-robin on conflict, drives the RAM port.
//  Returns read data with a per-requester readdatavalid, matched to the RAM read latency.
// PARAMETERS
//  ADDR_W      8   RAM word-address width (256 words)
//  DATA_W      32  data width; byteenable width = DATA_W/8
//  RD_LATENCY  1   RAM clocks from address to q (1 = unregistered q, 2 = registered q)
// PORTS
//  clk              in   1       system clock
//  reset            in   1       synchronous, active-high reset
//  stall            in   1       global freeze: no grants, RAM clock-enable low
//  a_chipselect, a_read, a_write  in  1 each  port A request qualifiers
//  a_address        in   ADDR_W  port A word address
//  a_byteenable     in   DATA_W/8 port A write byte lanes
//  a_writedata      in   DATA_W  port A write data
//  a_waitrequest    out  1       port A request not accepted this cycle
//  a_readdatavalid  out  1       port A read data valid on a_readdata
//  a_readdata       out  DATA_W  port A read data
//  b_*              --   --      identical set for port B
//  ram_chipselect, ram_write  out  1  to RAM; RAM write enable = chipselect & write
//  ram_clken        out  1       RAM clock enable
//  ram_address      out  ADDR_W  to RAM
//  ram_byteenable   out  DATA_W/8 to RAM
//  ram_writedata    out  DATA_W  to RAM
//  ram_readdata     in   DATA_W  RAM q
// BEHAVIOUR
//  - Request on port X: x_chipselect & (x_read | x_write). If read and write are both high, treat as a write; no readdatavalid.
//  - Grant is combinational in the cycle.
//    - Sole requester wins.
//    - If both request, the port not granted last wins.
//    - last_grant register resets to B, so A wins the first conflict.
//    - last_grant updates only on a cycle with a grant.
//  - x_waitrequest = request & ~grant_x; also high for any request while stall=1.
//  - Idle port: waitrequest low.
//  - RAM mux: ram_* carry the granted port's fields.
//    - With no grant: ram_chipselect=0, ram_write=0; address, data and byteenable hold the A fields (don't-care).
//  - ram_clken = ~stall. Accepted write takes effect at the grant edge. byteenable=0 writes nothing.
//  - Read return uses a shift register, RD_LATENCY stages, entry {valid, port}.
//    - A granted read enters stage 0 at the grant edge.
//    - x_readdatavalid = last stage valid & port==X; x_readdata = ram_readdata, fanned out to both ports.
//    - Read latency as seen by a requester = RD_LATENCY cycles after the accept edge.
//    - Back-to-back reads are accepted every cycle. No outstanding limit beyond pipe depth.
//  - stall=1: no grants, the shift register holds (it advances only when ram_clken=1), readdatavalid forced low.
//  - reset (sync): last_grant=B, all pipe valids=0, in-flight reads dropped. All waitrequest/readdatavalid/ram_chipselect=0 in the reset cycle.
//  - Reset mid-read: the result is never signalled. The requester must reissue.
// STRUCTURE
//  - Shared package descf_pkg: ADDR_W/DATA_W defaults, port id enum {PORT_A=0, PORT_B=1}, pipe entry struct {valid, port}.
//  - One sub-module: descf_rd_tag_pipe (RD_LATENCY-deep valid/port shift register with enable).
//  - The arbiter/mux stays in the top level.
// TESTING
//  1. After reset, A reads addr 0x10 (RAM preloaded 0x10=0xCAFEF00D): no wait; a_readdatavalid exactly RD_LATENCY later with 0xCAFEF00D; b_readdatavalid stays 0.
//  2. A and B read simultaneously, 4 cycles, addresses 1..4: grants alternate A,B,A,B; each waitrequest high on its off cycles; data returns in grant order, tagged to the right port.
//  3. B writes 0x20=0x11223344 with byteenable 4'b0101, then A reads 0x20 (prior 0): A gets 0x00220044.
//  4. A streams reads every cycle, B idle: zero waitrequest; one readdatavalid per cycle; data matches the address sequence.
//  5. stall high for 3 cycles with reads in flight: no grants, no readdatavalid, ram_clken=0. After release, pending data returns unchanged.
//  6. reset asserted the cycle after a read is accepted: no readdatavalid ever for it; the next conflict grants A first.

Source files
------------

// File: rtl/descf_pkg.sv
// Shared types for the descriptor-RAM arbiter: port identifiers and the read-return tag.
package descf_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } rd_tag_t;

endpackage

// File: rtl/descf_rd_tag_pipe.sv
// Read-return tag shift register: carries {valid, port} alongside the RAM read latency.
module descf_rd_tag_pipe
  import descf_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  logic [STAGES-1:0] vld_p;
  port_e             port_p [STAGES];

  // Valid bits are control: cleared by reset so in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (en) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        vld_p[i] <= vld_p[i-1];
      end
      vld_p[0] <= tag_in.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        port_p[i] <= port_p[i-1];
      end
      port_p[0] <= tag_in.port;
    end
  end

  assign tag_out.valid = vld_p[STAGES-1];
  assign tag_out.port  = port_p[STAGES-1];

endmodule

// File: rtl/descf_arbiter.sv
// Two-port round-robin arbiter in front of the single-port descriptor RAM,
// returning read data to the requester that issued it.
module descf_arbiter
  import descf_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                a_chipselect,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic                a_readdatavalid,
  output logic [DATA_W-1:0]   a_readdata,
  input  logic                b_chipselect,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic                b_readdatavalid,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic    req_a, req_b;
  logic    gnt_a, gnt_b;
  port_e   last_grant;
  rd_tag_t tag_in, tag_out;
  logic    rdv_ok;

  assign req_a = a_chipselect & (a_read | a_write);
  assign req_b = b_chipselect & (b_read | b_write);

  // Grant is decided within the cycle; on conflict the port not served last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset && !stall) begin
      if (req_a && (!req_b || last_grant == PORT_B)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign a_waitrequest = ~reset & req_a & ~gnt_a;
  assign b_waitrequest = ~reset & req_b & ~gnt_b;

  always_comb begin
    ram_address    = a_address;
    ram_byteenable = a_byteenable;
    ram_writedata  = a_writedata;
    ram_write      = gnt_a & a_write;
    if (gnt_b) begin
      ram_address    = b_address;
      ram_byteenable = b_byteenable;
      ram_writedata  = b_writedata;
      ram_write      = b_write;
    end
  end

  assign ram_chipselect = gnt_a | gnt_b;
  assign ram_clken      = ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_B;
    end else if (gnt_a) begin
      last_grant <= PORT_A;
    end else if (gnt_b) begin
      last_grant <= PORT_B;
    end
  end

  // A write with read also asserted is a write and produces no return tag.
  always_comb begin
    tag_in.valid = (gnt_a & ~a_write) | (gnt_b & ~b_write);
    tag_in.port  = gnt_b ? PORT_B : PORT_A;
  end

  descf_rd_tag_pipe #(
    .STAGES (RD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .en      (ram_clken),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rdv_ok          = ~reset & ~stall & tag_out.valid;
  assign a_readdatavalid = rdv_ok & (tag_out.port == PORT_A);
  assign b_readdatavalid = rdv_ok & (tag_out.port == PORT_B);
  assign a_readdata      = ram_readdata;
  assign b_readdata      = ram_readdata;

endmodule

// File: tb/tb_descf_arbiter.sv
// Self-checking bench for descf_arbiter: RAM model plus a queue-based reference
// of grants and read returns.
module tb_descf_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset, stall;
  logic          a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
  logic [AW-1:0] a_address, b_address, ram_address;
  logic [BW-1:0] a_byteenable, b_byteenable, ram_byteenable;
  logic [DW-1:0] a_writedata, b_writedata, ram_writedata, ram_readdata;
  logic          a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
  logic [DW-1:0] a_readdata, b_readdata;
  logic          ram_chipselect, ram_write, ram_clken;

  always #5 clk = ~clk;

  descf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_waitrequest(a_waitrequest), .a_readdatavalid(a_readdatavalid), .a_readdata(a_readdata),
    .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_waitrequest(b_waitrequest), .b_readdatavalid(b_readdatavalid), .b_readdata(b_readdata),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  // Single-port RAM with clock enable; q returns the pre-write contents.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] q1, q2;
  always @(posedge clk) begin
    if (ram_clken) begin
      q1 <= ram_mem[ram_address];
      q2 <= q1;
      if (ram_chipselect && ram_write)
        for (int k = 0; k < BW; k++)
          if (ram_byteenable[k]) ram_mem[ram_address][8*k +: 8] = ram_writedata[8*k +: 8];
    end
  end
  assign ram_readdata = (LAT == 2) ? q2 : q1;

  // Reference model: memory image, last served port, queue of pending returns.
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            left;
  } pend_t;

  logic [DW-1:0] ref_mem [256];
  pend_t         pend[$];
  int            m_last = 1;
  logic          e_ga, e_gb, e_wa, e_wb, e_rva, e_rvb;
  logic [DW-1:0] e_data;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic model_eval();
    logic ra, rb;
    ra    = a_chipselect && (a_read || a_write);
    rb    = b_chipselect && (b_read || b_write);
    e_ga  = !reset && !stall && ra && (!rb || m_last == 1);
    e_gb  = !reset && !stall && rb && !e_ga;
    e_wa  = !reset && ra && !e_ga;
    e_wb  = !reset && rb && !e_gb;
    e_rva = 1'b0;
    e_rvb = 1'b0;
    e_data = '0;
    if (!reset && !stall && pend.size() > 0 && pend[0].left == 0) begin
      e_rva  = (pend[0].port == 0);
      e_rvb  = (pend[0].port == 1);
      e_data = pend[0].data;
    end
  endtask

  task automatic model_step();
    pend_t         p;
    logic          wr;
    logic [AW-1:0] ad;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    model_eval();
    if (reset) begin
      pend.delete();
      m_last = 1;
    end else if (!stall) begin
      if (pend.size() > 0 && pend[0].left == 0) void'(pend.pop_front());
      foreach (pend[i]) pend[i].left = pend[i].left - 1;
      if (e_ga || e_gb) begin
        wr = e_ga ? a_write : b_write;
        ad = e_ga ? a_address : b_address;
        be = e_ga ? a_byteenable : b_byteenable;
        wd = e_ga ? a_writedata : b_writedata;
        m_last = e_gb ? 1 : 0;
        if (wr) begin
          for (int k = 0; k < BW; k++)
            if (be[k]) ref_mem[ad][8*k +: 8] = wd[8*k +: 8];
        end else begin
          p.port = m_last;
          p.data = ref_mem[ad];
          p.left = LAT - 1;
          pend.push_back(p);
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    a_chipselect = 0; a_read = 0; a_write = 0;
    b_chipselect = 0; b_read = 0; b_write = 0;
  endtask

  task automatic rd_a(input logic [AW-1:0] ad);
    a_chipselect = 1; a_read = 1; a_write = 0; a_address = ad;
  endtask

  task automatic rd_b(input logic [AW-1:0] ad);
    b_chipselect = 1; b_read = 1; b_write = 0; b_address = ad;
  endtask

  task automatic do_reset(input int n);
    reset = 1; idle();
    repeat (n) begin settle(); advance(); end
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0;
    rd_a(8'h05);
    b_chipselect = 1; b_read = 0; b_write = 1; b_address = 8'h06;
    settle();
    n_vec++;
    if ({a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid, ram_chipselect} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000",
               {a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid, ram_chipselect});
    end
    advance(); advance();
    reset = 0; idle();
  endtask

  task automatic preload();
    logic [DW-1:0] v;
    for (int i = 0; i <= 32; i++) begin
      v = $urandom;
      if (i == 16) v = 32'hCAFEF00D;
      if (i == 32) v = '0;
      a_chipselect = 1; a_read = 0; a_write = 1;
      a_address = i[AW-1:0]; a_byteenable = '1; a_writedata = v;
      settle(); advance();
    end
    idle();
  endtask

  task automatic test_single_read();
    do_reset(1);
    rd_a(8'h10);
    settle();
    n_vec++;
    if ({a_waitrequest, ram_chipselect, ram_address} !== {1'b0, 1'b1, 8'h10}) begin
      n_err++;
      $display("FAIL single_accept: got wait=%b cs=%b addr=%h want 0 1 10", a_waitrequest, ram_chipselect, ram_address);
    end
    advance(); idle();
    for (int c = 1; c <= LAT + 1; c++) begin
      settle();
      n_vec++;
      if (c == LAT) begin
        if ({a_readdatavalid, b_readdatavalid, a_readdata} !== {2'b10, 32'hCAFEF00D}) begin
          n_err++;
          $display("FAIL single_return: got rdv=%b%b data=%h want 10 cafef00d", a_readdatavalid, b_readdatavalid, a_readdata);
        end
      end else if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin
        n_err++;
        $display("FAIL single_quiet c=%0d: got rdv=%b%b want 00", c, a_readdatavalid, b_readdatavalid);
      end
      advance();
    end
  endtask

  task automatic test_conflict();
    do_reset(1);
    rd_a(8'd1); rd_b(8'd2);
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i >= 4) idle();
      settle();
      if (i < 4) begin
        n_vec++;
        if ({a_waitrequest, b_waitrequest} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL conflict_wait i=%0d: got %b%b want %b", i, a_waitrequest, b_waitrequest,
                   (i % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      n_vec++;
      if (i >= LAT) begin
        if ({a_readdatavalid, b_readdatavalid} !== (((i - LAT) % 2 == 0) ? 2'b10 : 2'b01) ||
            a_readdata !== ref_mem[i - LAT + 1]) begin
          n_err++;
          $display("FAIL conflict_return i=%0d: got rdv=%b%b data=%h want port %0d data=%h", i,
                   a_readdatavalid, b_readdatavalid, a_readdata, (i - LAT) % 2, ref_mem[i - LAT + 1]);
        end
      end else if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin
        n_err++;
        $display("FAIL conflict_early i=%0d: got rdv=%b%b want 00", i, a_readdatavalid, b_readdatavalid);
      end
      advance();
      if (i == 0) a_address = 8'd3;
      if (i == 1) b_address = 8'd4;
    end
  endtask

  task automatic test_byte_write();
    b_chipselect = 1; b_read = 0; b_write = 1;
    b_address = 8'h20; b_byteenable = 4'b0101; b_writedata = 32'h11223344;
    settle();
    n_vec++;
    if ({b_waitrequest, ram_chipselect, ram_write} !== 3'b011) begin
      n_err++;
      $display("FAIL bwrite_accept: got %b%b%b want 011", b_waitrequest, ram_chipselect, ram_write);
    end
    advance(); idle();
    rd_a(8'h20);
    settle(); advance(); idle();
    for (int c = 1; c < LAT; c++) begin settle(); advance(); end
    settle();
    n_vec++;
    if ({a_readdatavalid, a_readdata} !== {1'b1, 32'h00220044}) begin
      n_err++;
      $display("FAIL bwrite_readback: got rdv=%b data=%h want 1 00220044", a_readdatavalid, a_readdata);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs[$];
    for (int i = 0; i < 10 + LAT; i++) begin
      if (i < 10) begin
        rd_a(8'($urandom_range(0, 31)));
        addrs.push_back(a_address);
      end else idle();
      settle();
      if (i < 10) begin
        n_vec++;
        if (a_waitrequest !== 1'b0) begin
          n_err++;
          $display("FAIL stream_wait i=%0d: got %b want 0", i, a_waitrequest);
        end
      end
      if (i >= LAT) begin
        n_vec++;
        if ({a_readdatavalid, b_readdatavalid, a_readdata} !== {2'b10, ref_mem[addrs[i - LAT]]}) begin
          n_err++;
          $display("FAIL stream_data i=%0d: got rdv=%b%b data=%h want 10 %h", i, a_readdatavalid,
                   b_readdatavalid, a_readdata, ref_mem[addrs[i - LAT]]);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] x;
    x = 8'($urandom_range(0, 31));
    rd_a(x);
    settle(); advance();
    stall = 1;
    rd_a(8'($urandom_range(0, 31)));
    for (int c = 0; c < 3; c++) begin
      settle();
      n_vec++;
      if ({a_waitrequest, ram_chipselect, ram_clken, a_readdatavalid, b_readdatavalid} !== 5'b10000) begin
        n_err++;
        $display("FAIL stall_freeze c=%0d: got %b want 10000", c,
                 {a_waitrequest, ram_chipselect, ram_clken, a_readdatavalid, b_readdatavalid});
      end
      advance();
    end
    stall = 0; idle();
    for (int c = 0; c < LAT; c++) begin
      settle();
      if (c == LAT - 1) begin
        n_vec++;
        if ({a_readdatavalid, a_readdata} !== {1'b1, ref_mem[x]}) begin
          n_err++;
          $display("FAIL stall_release: got rdv=%b data=%h want 1 %h", a_readdatavalid, a_readdata, ref_mem[x]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_read();
    rd_a(8'h07);
    settle(); advance();
    reset = 1; idle();
    for (int c = 0; c < LAT + 3; c++) begin
      if (c == 1) reset = 0;
      settle();
      n_vec++;
      if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_drop c=%0d: got rdv=%b%b want 00", c, a_readdatavalid, b_readdatavalid);
      end
      advance();
    end
    rd_a(8'd1); rd_b(8'd2);
    settle();
    n_vec++;
    if ({a_waitrequest, b_waitrequest} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b%b want 01", a_waitrequest, b_waitrequest);
    end
    advance(); idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500 + LAT + 1; i++) begin
      if (i < 500) begin
        reset = ($urandom_range(0, 59) == 0);
        stall = ($urandom_range(0, 7) == 0);
        a_chipselect = ($urandom_range(0, 3) != 0); a_read = 1'($urandom);
        a_write = ($urandom_range(0, 2) == 0); a_address = 8'($urandom_range(0, 15));
        a_byteenable = 4'($urandom); a_writedata = $urandom;
        b_chipselect = ($urandom_range(0, 3) != 0); b_read = 1'($urandom);
        b_write = ($urandom_range(0, 2) == 0); b_address = 8'($urandom_range(0, 15));
        b_byteenable = 4'($urandom); b_writedata = $urandom;
      end else begin
        reset = 0; stall = 0; idle();
      end
      settle();
      n_vec++;
      if ({a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid, ram_chipselect, ram_clken} !==
          {e_wa, e_wb, e_rva, e_rvb, e_ga | e_gb, !stall}) begin
        n_err++;
        $display("FAIL random_ctrl i=%0d: got %b want %b", i,
                 {a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid, ram_chipselect, ram_clken},
                 {e_wa, e_wb, e_rva, e_rvb, e_ga | e_gb, !stall});
      end
      if (e_rva || e_rvb) begin
        n_vec++;
        if ((e_rva ? a_readdata : b_readdata) !== e_data) begin
          n_err++;
          $display("FAIL random_data i=%0d: got %h want %h", i, e_rva ? a_readdata : b_readdata, e_data);
        end
      end
      if (e_ga || e_gb) begin
        n_vec++;
        if ({ram_address, ram_write} !== (e_ga ? {a_address, a_write} : {b_address, b_write})) begin
          n_err++;
          $display("FAIL random_mux i=%0d: got %h/%b want %h/%b", i, ram_address, ram_write,
                   e_ga ? a_address : b_address, e_ga ? a_write : b_write);
        end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1; stall = 0; idle();
    a_address = '0; a_byteenable = '1; a_writedata = '0;
    b_address = '0; b_byteenable = '1; b_writedata = '0;
    test_reset();
    preload();
    test_single_read();
    test_conflict();
    test_byte_write();
    test_back_to_back();
    test_stall();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
